// File: rtl/rr_onehot_arbiter.sv
// Registered round-robin arbiter driving the one-hot select of a 4:1 mux.
// Grants advance only on a valid/ready transfer; a locked holder keeps the grant for bursts.
module rr_onehot_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] lock_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_valid_o,
   input  logic               gnt_ready_i
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [NUM_REQ-1:0] gnt_reg, gnt_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [IDX_W-1:0]   ptr_reg, ptr_next;

   logic [IDX_W-1:0]   scan_ptr;
   logic [IDX_W-1:0]   cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] cand_hit;
   logic [IDX_W-1:0]   win_idx;
   logic               any_req;
   logic               holder_locked;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
      if (v == IDX_W'(NUM_REQ - 1))
         return '0;
      else
         return v + 1'b1;
   endfunction

   function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] v);
      logic [NUM_REQ-1:0] oh;
      oh    = '0;
      oh[v] = 1'b1;
      return oh;
   endfunction

   // After a transfer the scan must start just past the served requester,
   // so the same-edge re-arbitration already sees the updated pointer.
   always_comb begin
      if (state_reg == GRANT)
         scan_ptr = wrap_inc(idx_reg);
      else
         scan_ptr = ptr_reg;
   end

   // Candidate gi is the requester gi places after the scan start, wrapped.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [IDX_W:0] raw;
         assign raw          = {1'b0, scan_ptr} + (IDX_W+1)'(gi);
         assign cand_idx[gi] = (raw >= (IDX_W+1)'(NUM_REQ))
                               ? IDX_W'(raw - (IDX_W+1)'(NUM_REQ))
                               : raw[IDX_W-1:0];
         assign cand_hit[gi] = req_i[cand_idx[gi]];
      end
   endgenerate

   // Walk from the far end so the nearest requester overwrites the rest.
   always_comb begin
      win_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_hit[k])
            win_idx = cand_idx[k];
      end
   end

   assign any_req       = |req_i;
   assign holder_locked = lock_i[idx_reg] & req_i[idx_reg];

   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      idx_next   = idx_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               state_next = GRANT;
               gnt_next   = to_onehot(win_idx);
               idx_next   = win_idx;
            end
         end
         GRANT: begin
            if (gnt_ready_i && !holder_locked) begin
               ptr_next = wrap_inc(idx_reg);
               if (any_req) begin
                  gnt_next = to_onehot(win_idx);
                  idx_next = win_idx;
               end else begin
                  state_next = IDLE;
                  gnt_next   = '0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_reg <= IDLE;
         gnt_reg   <= '0;
         idx_reg   <= '0;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         idx_reg   <= idx_next;
         ptr_reg   <= ptr_next;
      end
   end

   assign gnt_o       = gnt_reg;
   assign gnt_idx_o   = idx_reg;
   assign gnt_valid_o = (state_reg == GRANT);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed scenarios plus random traffic against a queue-free
// behavioural model (valid flag, holder index, priority pointer).
module tb_rr_onehot_arbiter;

   localparam int N = 4;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic [N-1:0] req_i;
   logic [N-1:0] lock_i;
   logic [N-1:0] gnt_o;
   logic [1:0]   gnt_idx_o;
   logic         gnt_valid_o;
   logic         gnt_ready_i;

   int n_checks = 0;
   int n_errors = 0;

   int m_valid;
   int m_idx;
   int m_ptr;

   rr_onehot_arbiter #(.NUM_REQ(N), .IDX_W(2)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .req_i       (req_i),
      .lock_i      (lock_i),
      .gnt_o       (gnt_o),
      .gnt_idx_o   (gnt_idx_o),
      .gnt_valid_o (gnt_valid_o),
      .gnt_ready_i (gnt_ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // First requester at or after p going round the ring; -1 if none.
   function automatic int pick(input int p, input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N])
            return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      m_idx   = 0;
      m_ptr   = 0;
   endtask

   task automatic model_edge();
      int w;
      if (m_valid == 0) begin
         w = pick(m_ptr, req_i);
         if (w >= 0) begin
            m_valid = 1;
            m_idx   = w;
         end
      end else if (gnt_ready_i) begin
         if (!(lock_i[m_idx] && req_i[m_idx])) begin
            m_ptr = (m_idx + 1) % N;
            w     = pick(m_ptr, req_i);
            if (w >= 0)
               m_idx = w;
            else
               m_valid = 0;
         end
      end
   endtask

   task automatic compare_model(input string tag);
      logic [N-1:0] exp_gnt;
      exp_gnt = '0;
      if (m_valid != 0)
         exp_gnt[m_idx] = 1'b1;
      check({tag, "_valid"}, 32'(gnt_valid_o), 32'(m_valid));
      check({tag, "_gnt"}, 32'(gnt_o), 32'(exp_gnt));
      if (m_valid != 0)
         check({tag, "_idx"}, 32'(gnt_idx_o), 32'(m_idx));
   endtask

   // One clock: model follows the edge with the inputs that were stable before it.
   task automatic tick(input string tag);
      @(posedge clk_i);
      model_edge();
      #1;
      compare_model(tag);
      $display("%s: req=%b lock=%b rdy=%b -> gnt=%b idx=%0d vld=%b",
               tag, req_i, lock_i, gnt_ready_i, gnt_o, gnt_idx_o, gnt_valid_o);
   endtask

   // Reset asserted between edges; outputs must clear without any clock.
   task automatic async_reset(input string tag);
      reset_i = 1'b1;
      model_reset();
      #1;
      check({tag, "_rst_gnt"}, 32'(gnt_o), 32'h0);
      check({tag, "_rst_vld"}, 32'(gnt_valid_o), 32'h0);
      #2;
      reset_i = 1'b0;
   endtask

   initial begin
      reset_i     = 1'b1;
      req_i       = '0;
      lock_i      = '0;
      gnt_ready_i = 1'b0;
      model_reset();
      @(posedge clk_i);
      #1;
      check("reset_gnt", 32'(gnt_o), 32'h0);
      check("reset_vld", 32'(gnt_valid_o), 32'h0);
      check("reset_idx", 32'(gnt_idx_o), 32'h0);
      reset_i = 1'b0;

      // single requester 2, then all requesters: pointer must now sit at 3
      req_i = 4'b0100; gnt_ready_i = 1'b1;
      tick("t1a"); check("t1a_lit", 32'(gnt_o), 32'h4); check("t1a_idx", 32'(gnt_idx_o), 32'd2);
      tick("t1b"); check("t1b_lit", 32'(gnt_o), 32'h4);
      req_i = 4'b1111;
      tick("t1c"); check("t1c_lit", 32'(gnt_o), 32'h8);

      // fairness rotation with no bubbles
      async_reset("t2");
      req_i = 4'b1111; lock_i = '0; gnt_ready_i = 1'b1;
      tick("t2a"); check("t2a_lit", 32'(gnt_o), 32'h1);
      tick("t2b"); check("t2b_lit", 32'(gnt_o), 32'h2);
      tick("t2c"); check("t2c_lit", 32'(gnt_o), 32'h4);
      tick("t2d"); check("t2d_lit", 32'(gnt_o), 32'h8);
      tick("t2e"); check("t2e_lit", 32'(gnt_o), 32'h1);

      // stall holds the grant even when the holder drops its request
      async_reset("t3");
      req_i = 4'b0011; gnt_ready_i = 1'b0;
      tick("t3a"); check("t3a_lit", 32'(gnt_o), 32'h1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) req_i = 4'b0010;
         tick("t3s"); check("t3s_lit", 32'(gnt_o), 32'h1);
      end
      gnt_ready_i = 1'b1;
      tick("t3b"); check("t3b_lit", 32'(gnt_o), 32'h2);

      // locked burst, then release
      async_reset("t4");
      req_i = 4'b0101; lock_i = 4'b0001; gnt_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick("t4l"); check("t4l_lit", 32'(gnt_o), 32'h1);
      end
      lock_i = '0;
      tick("t4a"); check("t4a_lit", 32'(gnt_o), 32'h4);
      tick("t4b"); check("t4b_lit", 32'(gnt_o), 32'h1);

      // drop to idle and regrant
      async_reset("t5");
      req_i = 4'b1000; lock_i = '0; gnt_ready_i = 1'b1;
      tick("t5a"); check("t5a_lit", 32'(gnt_o), 32'h8);
      req_i = 4'b0000;
      tick("t5b"); check("t5b_gnt", 32'(gnt_o), 32'h0); check("t5b_vld", 32'(gnt_valid_o), 32'h0);
      req_i = 4'b0001;
      tick("t5c"); check("t5c_lit", 32'(gnt_o), 32'h1);

      // reset mid-grant, pointer back to 0
      async_reset("t6p");
      req_i = 4'b0100;
      tick("t6a"); check("t6a_lit", 32'(gnt_o), 32'h4);
      async_reset("t6");
      req_i = 4'b1111;
      tick("t6b"); check("t6b_lit", 32'(gnt_o), 32'h1);

      // ready while idle is ignored
      async_reset("t7");
      req_i = '0; gnt_ready_i = 1'b1;
      tick("t7a");

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         req_i       = N'($urandom);
         lock_i      = N'($urandom);
         gnt_ready_i = ($urandom_range(3) != 0);
         if ($urandom_range(199) == 0)
            async_reset("rnd");
         tick("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got=running expected=done");
      $fatal(1);
   end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Registered round-robin arbiter that sits directly upstream of the 4:1 one-hot select mux.
- Arbitrates NUM_REQ request lines and drives a one-hot grant vector straight onto the mux select input.
- Also provides a binary grant index and a valid/ready handshake, so the consumer of the mux output controls when the grant advances.
- Supports locked bursts: a requester holds the grant for several consecutive transfers.

Parameters:
- NUM_REQ, 4, number of requesters; width of req_i, lock_i and gnt_o (must be ≥2).
- IDX_W, 2, width of gnt_idx_o; must equal clog2(NUM_REQ).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  reset, asynchronous and active-high.
- req_i  input  NUM_REQ  request per requester, level-sensitive.
- lock_i  input  NUM_REQ  per-requester burst lock; only the bit of the current grant holder is used.
- gnt_o  output  NUM_REQ  one-hot grant, registered; connects to the mux select input. All zeros when idle.
- gnt_idx_o  output  IDX_W  binary index of the granted requester, registered.
- gnt_valid_o  output  1  grant is valid and the mux output is meaningful.
- gnt_ready_i  input  1  downstream accepts the current transfer.

Behaviour:
- Reset (asynchronous, active-high):
  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, state=IDLE, priority pointer ptr=0.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- Winner selection (combinational, internal): scan req_i from index ptr upward, wrapping at NUM_REQ-1 to 0. The first set bit wins.
- States: IDLE, GRANT.
- IDLE:
  - gnt_valid_o=0, gnt_o=0.
  - If |req_i at a rising edge: register the winner into gnt_o and gnt_idx_o, set gnt_valid_o=1, go to GRANT.
  - Request-to-grant latency is one cycle.
- GRANT:
  - gnt_valid_o=1.
  - gnt_o and gnt_idx_o are held stable while gnt_ready_i=0, even if req_i of the holder drops or other requests change.
- Transfer: occurs on a rising edge with gnt_valid_o=1 and gnt_ready_i=1.
- On a transfer, when lock_i[gnt_idx_o]=1 and req_i[gnt_idx_o]=1:
  - Keep the same grant and stay in GRANT.
  - ptr is not changed.
- On a transfer otherwise:
  - ptr becomes (gnt_idx_o+1) mod NUM_REQ.
  - If |req_i, re-arbitrate in the same edge using the updated ptr, giving back-to-back grants with no idle bubble. req_i of the just-served requester counts only after the wrap.
  - If no requests, go to IDLE and clear gnt_o and gnt_valid_o.
- Invariants:
  - gnt_o is always one-hot or zero.
  - gnt_o is zero exactly when gnt_valid_o=0.
  - gnt_o == (1 << gnt_idx_o) whenever gnt_valid_o=1.
- Fairness: with all requesters asserted and no lock, grants rotate 0,1,2,3,0,… One grant per transfer.
- lock_i bits of non-holders are ignored.
- A lock whose holder deasserts req_i ends the burst at the next transfer.
- gnt_ready_i asserted while in IDLE is ignored.
- No combinational path from req_i or lock_i to any output. gnt_ready_i affects outputs only through registers.

Test Plan:
- Reset, then req_i=4'b0100 held, gnt_ready_i=1 → on the first edge gnt_o=4'b0100, gnt_idx_o=2, gnt_valid_o=1. Next grant is again 0100 (only requester); ptr moves to 3.
- req_i=4'b1111, gnt_ready_i=1 constantly, lock_i=0 → gnt_o sequence 0001,0010,0100,1000,0001 on consecutive cycles, with no bubbles.
- req_i=4'b0011, gnt_ready_i=0 for 5 cycles after grant 0001, with req_i changed to 4'b0010 during the stall → gnt_o stays 0001. On ready=1, the next grant is 0010.
- req_i=4'b0101, lock_i=4'b0001, ready=1 → three transfers with gnt_o=0001. Then lock_i=0 → next grant 0100, then 0001.
- Single request 4'b1000 accepted, then req_i=0 → gnt_valid_o=0 and gnt_o=0 the cycle after acceptance. A new req 4'b0001 is granted one cycle later.
- Assert reset_i mid-cycle while gnt_o=0100 → gnt_o=0 and gnt_valid_o=0 immediately. After release with req_i=4'b1111, the first grant is 0001 (ptr reset to 0).
